// File: rtl/pll_mode_reconfig_if.sv
// Avalon-MM PLL reconfig management port as seen from the sequencer.
interface pll_mode_reconfig_if;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_write,
        output mgmt_address,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_write,
        input  mgmt_address,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );
endinterface

// File: rtl/pll_mode_reconfig.sv
// Multi-mode PLL reconfiguration sequencer.
// Watches an asynchronous mode select and, on a change, replays a per-mode
// register write list on the PLL reconfig management port.
// Optional lock supervision with retries is enabled by PLL_RECFG_LOCK_CHECK_EN.
module pll_mode_reconfig #(
    parameter int unsigned         MODES      = 2,
    parameter int unsigned         MODE_W     = 1,
    parameter logic [MODES*32-1:0] FRAC_TABLE = {32'h15448515, 32'h29E2B79B},
    parameter bit                  WRITE_MC   = 1'b0,
    parameter logic [MODES*32-1:0] M_TABLE    = '0,
    parameter logic [MODES*32-1:0] C_TABLE    = '0
`ifdef PLL_RECFG_LOCK_CHECK_EN
    ,
    parameter int unsigned         LOCK_TIMEOUT = 50000,
    parameter int unsigned         MAX_RETRY    = 2
`endif
) (
    input  logic                   CLK_50M,
    input  logic                   reset,
    input  logic [MODE_W-1:0]      mode_in,
    input  logic                   locked,
    pll_mode_reconfig_if.master    mgmt,
    output logic                   busy,
    output logic [MODE_W-1:0]      cur_mode,
    output logic                   error
);

    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = WRITE_MC ? IDX_W'(4) : IDX_W'(2);
    localparam logic [IDX_W-1:0] FRAC_IDX = LAST_IDX - IDX_W'(1);

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_FRAC  = 6'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_LOCKWAIT,
        S_FINISH
    } state_t;

    state_t              state;
    logic [MODE_W-1:0]   mode_meta;
    logic [MODE_W-1:0]   mode_s;
    logic [MODE_W-1:0]   tgt;
    logic [IDX_W-1:0]    idx;
    logic                write_q;
    logic [5:0]          addr_q;
    logic [31:0]         data_q;

    logic                request;
    logic [IDX_W-1:0]    lut_idx;
    logic [MODE_W+4:0]   tbl_base;
    logic [5:0]          lut_addr;
    logic [31:0]         lut_data;

`ifdef PLL_RECFG_LOCK_CHECK_EN
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

    logic                lock_meta;
    logic                lock_s;
    logic                seen_low;
    logic [TMO_W-1:0]    lock_cnt;
    logic [RTY_W-1:0]    retry;
`else
    logic                lock_unused;

    // Lock status is not supervised in this build.
    assign lock_unused = locked;
    assign error       = 1'b0;
`endif

    assign mgmt.mgmt_write     = write_q;
    assign mgmt.mgmt_address   = addr_q;
    assign mgmt.mgmt_writedata = data_q;

    // A new sequence is wanted when the synced mode is valid and differs from the programmed one.
    always_comb begin
        request = (mode_s != cur_mode) && (32'(mode_s) < MODES);
    end

    // Write-list lookup; in GAP it already points at the following entry.
    always_comb begin
        lut_idx  = (state == S_GAP) ? idx + IDX_W'(1) : idx;
        tbl_base = {tgt, 5'd0};
        lut_addr = ADDR_START;
        lut_data = 32'd0;
        if (lut_idx == IDX_W'(0)) begin
            lut_addr = ADDR_MODE;
        end else if (WRITE_MC && lut_idx == IDX_W'(1)) begin
            lut_addr = ADDR_M;
            lut_data = M_TABLE[tbl_base +: 32];
        end else if (WRITE_MC && lut_idx == IDX_W'(2)) begin
            lut_addr = ADDR_C;
            lut_data = C_TABLE[tbl_base +: 32];
        end else if (lut_idx == FRAC_IDX) begin
            lut_addr = ADDR_FRAC;
            lut_data = FRAC_TABLE[tbl_base +: 32];
        end
    end

    // Synchronisers plus sequencer FSM; all outputs registered.
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_meta <= '0;
            mode_s    <= '0;
            tgt       <= '0;
            idx       <= '0;
            write_q   <= 1'b0;
            addr_q    <= 6'd0;
            data_q    <= 32'd0;
            busy      <= 1'b0;
            cur_mode  <= '0;
`ifdef PLL_RECFG_LOCK_CHECK_EN
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            seen_low  <= 1'b0;
            lock_cnt  <= '0;
            retry     <= '0;
            error     <= 1'b0;
`endif
        end else begin
            mode_meta <= mode_in;
            mode_s    <= mode_meta;
`ifdef PLL_RECFG_LOCK_CHECK_EN
            lock_meta <= locked;
            lock_s    <= lock_meta;
`endif
            case (state)
                S_IDLE: begin
                    if (request) begin
                        tgt   <= mode_s;
                        idx   <= '0;
                        busy  <= 1'b1;
`ifdef PLL_RECFG_LOCK_CHECK_EN
                        retry <= '0;
`endif
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // First cycle after IDLE or a retry sets up the write; then hold until accepted.
                    if (!write_q) begin
                        write_q <= 1'b1;
                        addr_q  <= lut_addr;
                        data_q  <= lut_data;
                    end else if (!mgmt.mgmt_waitrequest) begin
                        write_q <= 1'b0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (idx == LAST_IDX) begin
`ifdef PLL_RECFG_LOCK_CHECK_EN
                        lock_cnt <= '0;
                        seen_low <= 1'b0;
                        state    <= S_LOCKWAIT;
`else
                        state    <= S_FINISH;
`endif
                    end else begin
                        idx     <= lut_idx;
                        write_q <= 1'b1;
                        addr_q  <= lut_addr;
                        data_q  <= lut_data;
                        state   <= S_ISSUE;
                    end
                end
`ifdef PLL_RECFG_LOCK_CHECK_EN
                S_LOCKWAIT: begin
                    // Relock is only trusted after the PLL was seen dropping lock first.
                    if (seen_low && lock_s) begin
                        error <= 1'b0;
                        state <= S_FINISH;
                    end else if (lock_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
                        if (retry < RTY_W'(MAX_RETRY)) begin
                            retry <= retry + RTY_W'(1);
                            idx   <= '0;
                            state <= S_ISSUE;
                        end else begin
                            error    <= 1'b1;
                            cur_mode <= tgt;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end else begin
                        lock_cnt <= lock_cnt + TMO_W'(1);
                        if (!lock_s) begin
                            seen_low <= 1'b1;
                        end
                    end
                end
`endif
                S_FINISH: begin
                    cur_mode <= tgt;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
